// File: rtl/sump_pkg.sv
// Shared definitions for the SUMP command front end.
//   - Opcode constants understood by the analyzer core.
//   - LONG_CMD_BIT: opcode bit that marks a long (opcode + 4 data bytes) command.
//   - state_t: parser FSM encoding.
package sump_pkg;

    localparam logic [7:0] OP_RESET    = 8'h00;
    localparam logic [7:0] OP_ARM      = 8'h01;
    localparam logic [7:0] OP_QUERY_ID = 8'h02;
    localparam logic [7:0] OP_DIVIDER  = 8'h80;
    localparam logic [7:0] OP_SIZE     = 8'h81;
    localparam logic [7:0] OP_FLAGS    = 8'h82;

    localparam int LONG_CMD_BIT = 7;

    typedef enum logic {
        IDLE = 1'b0,
        ARG  = 1'b1
    } state_t;

endpackage

// File: rtl/sump_cmd_timer.sv
// Inactivity timer for a partially received long command.
// Ports:
//   clock       in  core clock
//   extReset_n  in  asynchronous active-low reset
//   clear       in  restart the count (byte received, or parser not in ARG)
//   count_en    in  advance the count (parser in ARG with no byte this cycle)
//   expire      out combinational; high on the idle cycle that completes the timeout
module sump_cmd_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int          TIMER_WIDTH    = 20
) (
    input  logic clock,
    input  logic extReset_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    // expire fires on the cycle whose increment would bring the count to
    // TIMEOUT_CYCLES-1; the parser registers the abort at that edge, so the
    // abort pulse appears TIMEOUT_CYCLES clocks after the last byte's cycle.
    localparam logic [TIMER_WIDTH-1:0] LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 2);

    logic [TIMER_WIDTH-1:0] count;

    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 1'b1;
        end
    end

    assign expire = count_en && !clear && (count == LAST);

endmodule

// File: rtl/sump_cmd_parser.sv
// SUMP command parser: assembles raw receiver bytes into core commands.
//   Short command: one byte with opcode[7]=0.
//   Long command : opcode with opcode[7]=1 followed by 4 little-endian data bytes.
// Optional feature macro: SUMP_CMD_TIMEOUT_EN (abort a stalled long command).
// Ports:
//   clock        in   core clock, rising edge
//   extReset_n   in   asynchronous active-low reset
//   rx_data      in   received byte
//   rx_valid     in   1-cycle strobe qualifying rx_data, no backpressure
//   opcode       out  command opcode, updated only with execute
//   config_data  out  command argument, updated only with execute
//   execute      out  1-cycle pulse, command complete
//   cmd_pending  out  long command partially received
//   cmd_abort    out  1-cycle pulse, partial command dropped on timeout
module sump_cmd_parser
    import sump_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int          TIMER_WIDTH    = 20
) (
    input  logic        clock,
    input  logic        extReset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  opcode,
    output logic [31:0] config_data,
    output logic        execute,
    output logic        cmd_pending,
    output logic        cmd_abort
);

    state_t      state;
    logic [1:0]  cnt;
    logic [7:0]  shadow_op;
    // Only three data lanes are buffered; the fourth byte goes straight to
    // config_data on completion.
    logic [23:0] shadow_data;
    logic        timeout;
    logic        abort_r;

`ifdef SUMP_CMD_TIMEOUT_EN
    sump_cmd_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMER_WIDTH    (TIMER_WIDTH)
    ) u_timer (
        .clock      (clock),
        .extReset_n (extReset_n),
        .clear      ((state != ARG) || rx_valid),
        .count_en   ((state == ARG) && !rx_valid),
        .expire     (timeout)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, TIMER_WIDTH};
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            shadow_op   <= 8'h00;
            shadow_data <= 24'h0;
            opcode      <= 8'h00;
            config_data <= 32'h0;
            execute     <= 1'b0;
            abort_r     <= 1'b0;
        end else begin
            execute <= 1'b0;
            abort_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data[LONG_CMD_BIT]) begin
                            shadow_op <= rx_data;
                            cnt       <= 2'd0;
                            state     <= ARG;
                        end else begin
                            opcode      <= rx_data;
                            config_data <= 32'h0;
                            execute     <= 1'b1;
                        end
                    end
                end
                ARG: begin
                    if (rx_valid) begin
                        cnt <= cnt + 2'd1;
                        case (cnt)
                            2'd0: shadow_data[7:0]   <= rx_data;
                            2'd1: shadow_data[15:8]  <= rx_data;
                            2'd2: shadow_data[23:16] <= rx_data;
                            default: begin
                                opcode      <= shadow_op;
                                config_data <= {rx_data, shadow_data};
                                execute     <= 1'b1;
                                state       <= IDLE;
                            end
                        endcase
                    end else if (timeout) begin
                        state   <= IDLE;
                        abort_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_pending = (state == ARG);
    assign cmd_abort   = abort_r;

endmodule

// File: tb/tb_sump_cmd_parser.sv
module tb_sump_cmd_parser;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        extReset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  opcode;
    logic [31:0] config_data;
    logic        execute;
    logic        cmd_pending;
    logic        cmd_abort;

    sump_cmd_parser #(
        .TIMEOUT_CYCLES (TO),
        .TIMER_WIDTH    (8)
    ) dut (
        .clock       (clock),
        .extReset_n  (extReset_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .opcode      (opcode),
        .config_data (config_data),
        .execute     (execute),
        .cmd_pending (cmd_pending),
        .cmd_abort   (cmd_abort)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] cfg;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  cmd[$];      // bytes of the long command currently being received
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          idle = 0;
    int          abort_due = -1;
    logic [7:0]  hold_op = 8'h00;
    logic [31:0] hold_cfg = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a command is a list of bytes; short opcodes complete
    // alone, long opcodes complete after four more bytes.
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (!extReset_n) begin
            cmd.delete();
            sb.delete();
            idle = 0;
            hold_op = 8'h00;
            hold_cfg = 32'h0;
        end else if (rx_valid) begin
            idle = 0;
            if (cmd.size() == 0 && !rx_data[7]) begin
                hold_op = rx_data;
                hold_cfg = 32'h0;
                sb.push_back('{rx_data, 32'h0, cyc});
            end else begin
                cmd.push_back(rx_data);
                if (cmd.size() == 5) begin
                    hold_op = cmd[0];
                    hold_cfg = {cmd[4], cmd[3], cmd[2], cmd[1]};
                    sb.push_back('{hold_op, hold_cfg, cyc});
                    cmd.delete();
                end
            end
        end else if (cmd.size() != 0) begin
`ifdef SUMP_CMD_TIMEOUT_EN
            idle = idle + 1;
            if (idle == TO - 1) begin
                cmd.delete();
                idle = 0;
                abort_due = cyc;
            end
`endif
        end
    end

    // Monitor: compares DUT outputs against the scoreboard away from the active edge.
    always @(negedge clock) begin
        exp_t e;
        if (extReset_n) begin
            chk("pending", 32'(cmd_pending), 32'(cmd.size() != 0));
            chk("abort", 32'(cmd_abort), 32'(abort_due == cyc));
            if (execute) begin
                if (sb.size() == 0) begin
                    chk("spurious_execute", 32'(execute), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("exec_cycle", 32'(cyc), 32'(e.due));
                    chk("opcode", 32'(opcode), 32'(e.op));
                    chk("config_data", config_data, e.cfg);
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                chk("missing_execute", 32'(execute), 32'h1);
                void'(sb.pop_front());
            end
            chk("hold_opcode", 32'(opcode), 32'(hold_op));
            chk("hold_config", config_data, hold_cfg);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drive one byte for one cycle, then leave `gap` empty cycles.
    task automatic send(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        tick(gap);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_opcode"}, 32'(opcode), 32'h0);
        chk({tag, "_config"}, config_data, 32'h0);
        chk({tag, "_execute"}, 32'(execute), 32'h0);
        chk({tag, "_pending"}, 32'(cmd_pending), 32'h0);
        chk({tag, "_abort"}, 32'(cmd_abort), 32'h0);
    endtask

    initial begin
        #1;
        chk_zero("reset");
        tick(3);
        extReset_n = 1'b1;
        tick(1);

        // Short command.
        send(8'h01, 3);
        // Long command with gaps.
        send(8'h82, 3); send(8'hAA, 3); send(8'hBB, 3); send(8'hCC, 3); send(8'hDD, 3);
        // Back-to-back long then short.
        send(8'h80, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        send(8'h01, 3);
        // Resync bytes then a long command.
        for (int i = 0; i < 5; i++) send(8'h00, 0);
        send(8'hC0, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 3);
        // Reset in the middle of a long command.
        send(8'h81, 1); send(8'hAA, 1);
        extReset_n = 1'b0;
        #1;
        chk_zero("midreset");
        tick(1);
        extReset_n = 1'b1;
        send(8'h02, 3);

`ifdef SUMP_CMD_TIMEOUT_EN
        // Stalled long command, then a byte landing in the abort cycle.
        send(8'h81, 0); send(8'hAA, 20);
        send(8'h01, 3);
        send(8'h82, 0); send(8'h55, 0);
        tick(TO - 1);
        send(8'h01, 3);
`endif

        // Randomized traffic: mix of short and long commands, small gaps.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if ($urandom_range(0, 2) == 0) b[7] = 1'b0;
            send(b, $urandom_range(0, 2));
        end
        tick(5);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
